// File: rtl/des_pkg.sv
// DES constant tables, S-boxes, shift schedule and permutation helpers.
// Tables use the standard DES numbering, where bit 1 is the MSB.
package des_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Each S-box is 64 nibbles, row-major, entry 0 in the top nibble.
    localparam logic [255:0] SBOX_T [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[i])];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[i])];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
        return y;
    endfunction

    // Row comes from the outer two bits, column from the middle four.
    function automatic logic [3:0] sbox_lookup(input logic [2:0] n, input logic [5:0] x);
        logic [255:0] t;
        logic [5:0]   idx;
        logic [7:0]   pos;
        t   = SBOX_T[n];
        idx = {x[5], x[0], x[4:1]};
        pos = {~idx, 2'b00};
        return t[pos +: 4];
    endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES Feistel round: L' = R, R' = L ^ f(R, K).
module des_round
    import des_pkg::*;
(
    input  logic [31:0] l_in,
    input  logic [31:0] r_in,
    input  logic [47:0] subkey,
    output logic [31:0] l_out,
    output logic [31:0] r_out
);

    logic [47:0] mixed;
    logic [31:0] sbox_out;

    always_comb begin
        mixed    = e_expand(r_in) ^ subkey;
        sbox_out = '0;
        for (int n = 0; n < 8; n++) begin
            sbox_out[5'(31 - 4 * n) -: 4] = sbox_lookup(3'(n), mixed[6'(47 - 6 * n) -: 6]);
        end
    end

    assign l_out = r_in;
    assign r_out = l_in ^ p_perm(sbox_out);

endmodule

// File: rtl/des_iter_core.sv
// Iterative DES encrypt/decrypt core computing ROUNDS_PER_CYCLE rounds per clock
// with a valid/ready request side and a held result until the consumer takes it.
module des_iter_core
    import des_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter bit DEC_EN           = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_mode,
    input  logic [63:0] in_key,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
);

    localparam int LATENCY = 16 / ROUNDS_PER_CYCLE;

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
        ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rpc
        $error("des_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    state_e      state_q, state_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] key_c_q, key_c_d, key_d_q, key_d_d;
    logic        mode_q, mode_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] out_data_q, out_data_d;

    logic [47:0] subkey [ROUNDS_PER_CYCLE];
    logic [27:0] key_c_next, key_d_next, c_cur, d_cur;
    logic [3:0]  rnd;
    logic [4:0]  cnt_sum;
    logic [31:0] l_fin, r_fin;

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // Encrypt rotates before taking the subkey; decrypt takes it first and
    // then undoes the shift that encryption used at the mirrored round.
    always_comb begin
        c_cur  = key_c_q;
        d_cur  = key_d_q;
        rnd    = '0;
        subkey = '{default: '0};
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            rnd = cnt_q + 4'(j);
            if (mode_q) begin
                subkey[j] = pc2_perm({c_cur, d_cur});
                c_cur     = rotr28(c_cur, SHIFT_T[4'd15 - rnd] == 2);
                d_cur     = rotr28(d_cur, SHIFT_T[4'd15 - rnd] == 2);
            end else begin
                c_cur     = rotl28(c_cur, SHIFT_T[rnd] == 2);
                d_cur     = rotl28(d_cur, SHIFT_T[rnd] == 2);
                subkey[j] = pc2_perm({c_cur, d_cur});
            end
        end
        key_c_next = c_cur;
        key_d_next = d_cur;
    end

    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
        logic [31:0] l_i, r_i, l_o, r_o;
        if (g == 0) begin : g_first
            assign l_i = l_q;
            assign r_i = r_q;
        end else begin : g_next
            assign l_i = g_round[g-1].l_o;
            assign r_i = g_round[g-1].r_o;
        end
        des_round u_round (
            .l_in   (l_i),
            .r_in   (r_i),
            .subkey (subkey[g]),
            .l_out  (l_o),
            .r_out  (r_o)
        );
    end

    assign l_fin   = g_round[ROUNDS_PER_CYCLE-1].l_o;
    assign r_fin   = g_round[ROUNDS_PER_CYCLE-1].r_o;
    assign cnt_sum = {1'b0, cnt_q} + 5'(ROUNDS_PER_CYCLE);

    always_comb begin
        state_d    = state_q;
        l_d        = l_q;
        r_d        = r_q;
        key_c_d    = key_c_q;
        key_d_d    = key_d_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    {l_d, r_d}         = ip_perm(in_data);
                    {key_c_d, key_d_d} = pc1_perm(in_key);
                    mode_d             = in_mode & DEC_EN;
                    cnt_d              = '0;
                    state_d            = ST_RUN;
                end
            end
            ST_RUN: begin
                l_d     = l_fin;
                r_d     = r_fin;
                key_c_d = key_c_next;
                key_d_d = key_d_next;
                cnt_d   = cnt_sum[3:0];
                if (cnt_sum[4]) begin
                    out_data_d = fp_perm({r_fin, l_fin});
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            l_q        <= '0;
            r_q        <= '0;
            key_c_q    <= '0;
            key_d_q    <= '0;
            mode_q     <= 1'b0;
            cnt_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            l_q        <= l_d;
            r_q        <= r_d;
            key_c_q    <= key_c_d;
            key_d_q    <= key_d_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = out_data_q;

    // A full schedule rotates each half by 28, so C/D must come back unchanged.
    a_key_restored : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_DONE && $past(state_q) == ST_RUN) |->
        ({key_c_q, key_d_q} == $past({key_c_q, key_d_q}, LATENCY)));

endmodule

// File: tb/tb_des_iter_core.sv
// Directed scoreboard bench for des_iter_core at 1, 4 and 16 rounds per cycle.
module tb_des_iter_core;

    localparam int RPC_T [3] = '{1, 4, 16};
    localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
    localparam logic [63:0] P1  = 64'h0123456789ABCDEF;
    localparam logic [63:0] C1  = 64'h85E813540F0AB405;
    localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
    localparam logic [63:0] P2  = 64'h8787878787878787;
    localparam logic [63:0] KW  = 64'h0101010101010101;
    localparam logic [63:0] CW0 = 64'h8CA64DE9C1B123A7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  in_valid, in_mode, out_ready, in_ready, out_valid, busy;
    logic [63:0] in_key [3];
    logic [63:0] in_data [3];
    logic [63:0] out_data [3];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] sb_q [$];
    longint      last_accept;
    longint      t_prev;

    always #5 clk = ~clk;

    des_iter_core #(.ROUNDS_PER_CYCLE(1), .DEC_EN(1'b1)) u_dut_r1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_mode(in_mode[0]), .in_key(in_key[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .busy(busy[0]));

    des_iter_core #(.ROUNDS_PER_CYCLE(4), .DEC_EN(1'b1)) u_dut_r4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_mode(in_mode[1]), .in_key(in_key[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .busy(busy[1]));

    des_iter_core #(.ROUNDS_PER_CYCLE(16), .DEC_EN(1'b1)) u_dut_r16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_mode(in_mode[2]), .in_key(in_key[2]), .in_data(in_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .busy(busy[2]));

    task automatic checkEq(input string tag, input int d, input logic [63:0] obs,
                           input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s rpc=%0d observed=%h expected=%h", tag, RPC_T[d], obs, exp);
        end
    endtask

    // Waits for in_ready, presents one request, pushes its expected result
    // and scrambles the inputs after the accept edge.
    task automatic applyStimulus(input int d, input logic mode, input logic [63:0] key,
                                 input logic [63:0] data, input logic [63:0] exp);
        int waited = 0;
        @(negedge clk);
        while (!in_ready[d] && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkEq("in_ready_before_accept", d, 64'(in_ready[d]), 64'd1);
        in_valid[d] = 1'b1;
        in_mode[d]  = mode;
        in_key[d]   = key;
        in_data[d]  = data;
        sb_q.push_back(exp);
        @(posedge clk);
        last_accept = $time;
        #1;
        in_valid[d] = 1'b0;
        in_mode[d]  = ~mode;
        in_key[d]   = {$urandom, $urandom};
        in_data[d]  = {$urandom, $urandom};
    endtask

    // Waits for out_valid, checks latency and data against the scoreboard;
    // if out_ready is high also checks the return to IDLE one edge later.
    task automatic checkOutput(input int d, input string tag);
        int          cycles = 0;
        logic [63:0] exp_v;
        while (cycles < 40) begin
            @(posedge clk);
            cycles++;
            #1;
            if (out_valid[d]) break;
        end
        checkEq({tag, "_valid"}, d, 64'(out_valid[d]), 64'd1);
        checkEq({tag, "_latency"}, d, 64'(cycles), 64'(16 / RPC_T[d]));
        if (sb_q.size() != 0) exp_v = sb_q.pop_front();
        else exp_v = 'x;
        checkEq({tag, "_data"}, d, out_data[d], exp_v);
        if (out_ready[d]) begin
            @(posedge clk);
            #1;
            checkEq({tag, "_idle_valid"}, d, 64'(out_valid[d]), 64'd0);
            checkEq({tag, "_idle_ready"}, d, 64'(in_ready[d]), 64'd1);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        in_mode   = '0;
        out_ready = '1;
        for (int i = 0; i < 3; i++) begin
            in_key[i]  = '0;
            in_data[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checkEq("rst_out_valid", d, 64'(out_valid[d]), 64'd0);
            checkEq("rst_busy", d, 64'(busy[d]), 64'd0);
            checkEq("rst_out_data", d, out_data[d], 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) checkEq("post_rst_in_ready", d, 64'(in_ready[d]), 64'd1);

        for (int d = 0; d < 3; d++) begin
            $display("[TB] ROUNDS_PER_CYCLE=%0d", RPC_T[d]);
            out_ready[d] = 1'b1;

            applyStimulus(d, 1'b0, K1, P1, C1);
            checkOutput(d, "enc_k1");
            applyStimulus(d, 1'b1, K1, C1, P1);
            checkOutput(d, "dec_k1");
            applyStimulus(d, 1'b0, K2, P2, 64'd0);
            checkOutput(d, "enc_k2");
            applyStimulus(d, 1'b0, KW, 64'd0, CW0);
            checkOutput(d, "weak_first");
            applyStimulus(d, 1'b0, KW, CW0, 64'd0);
            checkOutput(d, "weak_second");

            out_ready[d] = 1'b0;
            applyStimulus(d, 1'b0, K1, P1, C1);
            checkOutput(d, "bp");
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                in_valid[d] = 1'b1;
                in_data[d]  = {$urandom, $urandom};
                @(posedge clk);
                #1;
                checkEq("bp_hold_valid", d, 64'(out_valid[d]), 64'd1);
                checkEq("bp_hold_data", d, out_data[d], C1);
                checkEq("bp_in_ready", d, 64'(in_ready[d]), 64'd0);
            end
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
            @(posedge clk);
            #1;
            checkEq("bp_release_valid", d, 64'(out_valid[d]), 64'd0);
            checkEq("bp_release_busy", d, 64'(busy[d]), 64'd0);
            checkEq("bp_release_ready", d, 64'(in_ready[d]), 64'd1);

            applyStimulus(d, 1'b0, K2, P1, 64'd0);
            repeat (8 / RPC_T[d]) @(posedge clk);
            #2;
            checkEq("mid_run_busy", d, 64'(busy[d]), 64'd1);
            rst_n = 1'b0;
            #1;
            checkEq("mid_rst_out_valid", d, 64'(out_valid[d]), 64'd0);
            checkEq("mid_rst_out_data", d, out_data[d], 64'd0);
            checkEq("mid_rst_busy", d, 64'(busy[d]), 64'd0);
            sb_q.delete();
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            checkEq("mid_rst_in_ready", d, 64'(in_ready[d]), 64'd1);
            applyStimulus(d, 1'b1, K1, C1, P1);
            checkOutput(d, "after_rst");

            applyStimulus(d, 1'b0, K1, P1, C1);
            t_prev = last_accept;
            checkOutput(d, "b2b_0");
            applyStimulus(d, 1'b0, K2, P2, 64'd0);
            checkEq("b2b_period_1", d, 64'((last_accept - t_prev) / 10), 64'(16 / RPC_T[d] + 2));
            t_prev = last_accept;
            checkOutput(d, "b2b_1");
            applyStimulus(d, 1'b1, K1, C1, P1);
            checkEq("b2b_period_2", d, 64'((last_accept - t_prev) / 10), 64'(16 / RPC_T[d] + 2));
            checkOutput(d, "b2b_2");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
